// File: rtl/pbuf2ddr.sv
// pbuf2ddr: reads PE parameter buffers back (PEs ascending, addresses 0..depth) and streams them to DDR.
// Optional feature macro PBUF2DDR_CHKSUM_EN appends an XOR checksum word after the data words.
module pbuf2ddr #(
    parameter int unsigned BUF_DEPTH  = 256,
    parameter int unsigned ADDR_W     = $clog2(BUF_DEPTH),
    parameter int unsigned PE_NUM     = 32,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BATCH      = 2,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DDR_W      = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             conf_valid,
    output logic                             conf_ready,
    input  logic [PE_NUM-1:0]                conf_mask,
    input  logic [ADDR_W-1:0]                conf_depth,
    output logic [PE_NUM-1:0]                pbuf_rd_en,
    output logic [ADDR_W-1:0]                pbuf_rd_addr,
    input  logic [PE_NUM*BATCH*DATA_W-1:0]   pbuf_rd_data,
    output logic [DDR_W-1:0]                 ddr_data,
    output logic                             ddr_valid,
    input  logic                             ddr_ready,
    output logic                             ddr_last
);

    localparam int unsigned LANE_W = BATCH * DATA_W;
    localparam int unsigned PE_W   = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
    localparam int unsigned FP_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CRD_W  = FP_W + 1;
    localparam int unsigned CNT_W  = 13;
    localparam int unsigned TW_W   = CNT_W + 1;
    localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;

    state_t                       state_q, state_d;
    logic [PE_NUM-1:0]            mask_q, mask_d;
    logic [ADDR_W-1:0]            depth_q, depth_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [CNT_W-1:0]             last_idx_q, last_idx_d;
    logic [CNT_W-1:0]             word_cnt_q, word_cnt_d;
    logic [CRD_W-1:0]             credit_q, credit_d;
    logic [CRD_W-1:0]             fcnt_q, fcnt_d;
    logic [FP_W-1:0]              wr_ptr_q, wr_ptr_d;
    logic [FP_W-1:0]              rd_ptr_q, rd_ptr_d;
    logic [RD_LAT-1:0]            vld_pipe_q, vld_pipe_d;
    logic [RD_LAT-1:0][PE_W-1:0]  pe_pipe_q, pe_pipe_d;
    logic [LANE_W-1:0]            fifo_mem_q [FIFO_DEPTH];

    logic                         accept, issue, push, pop, arrive;
    logic [PE_W-1:0]              cur_pe, arr_pe;
    logic [PE_NUM-1:0]            cur_bit;
    logic [LANE_W-1:0]            lane_data, push_data;
    logic [TW_W-1:0]              total_words;
    logic                         chk_push, chk_busy;
    logic [LANE_W-1:0]            chk_value;

    // Current PE is the lowest set bit of the working mask; returning lane picked by the piped index.
    always_comb begin
        cur_pe = '0;
        for (int unsigned i = PE_NUM; i > 0; i--) begin
            if (mask_q[i-1]) cur_pe = PE_W'(i - 1);
        end
        cur_bit         = '0;
        cur_bit[cur_pe] = 1'b1;
        arrive    = vld_pipe_q[RD_LAT-1];
        arr_pe    = pe_pipe_q[RD_LAT-1];
        lane_data = '0;
        for (int unsigned i = 0; i < PE_NUM; i++) begin
            if (arr_pe == PE_W'(i)) lane_data = pbuf_rd_data[i*LANE_W +: LANE_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        depth_d     = depth_q;
        addr_d      = addr_q;
        last_idx_d  = last_idx_q;
        total_words = '0;
        issue       = 1'b0;
        accept      = (state_q == ST_IDLE) && conf_valid;
        case (state_q)
            ST_IDLE: begin
                if (conf_valid) begin
                    for (int unsigned i = 0; i < PE_NUM; i++) begin
                        if (conf_mask[i]) total_words = total_words + TW_W'(conf_depth) + TW_W'(1);
                    end
                    mask_d  = conf_mask;
                    depth_d = conf_depth;
                    addr_d  = '0;
`ifdef PBUF2DDR_CHKSUM_EN
                    last_idx_d = CNT_W'(total_words);
`else
                    last_idx_d = CNT_W'(total_words - TW_W'(1));
`endif
                    state_d = (conf_mask != '0) ? ST_READ : ST_DRAIN;
                end
            end
            ST_READ: begin
                // Credits cover FIFO occupancy plus reads still in the pbuf pipe.
                if (credit_q < CRD_MAX) begin
                    issue = 1'b1;
                    if (addr_q == depth_q) begin
                        mask_d = mask_q & ~cur_bit;
                        addr_d = '0;
                        if ((mask_q & ~cur_bit) == '0) state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (vld_pipe_q == '0 && fcnt_q == '0 && !chk_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef PBUF2DDR_CHKSUM_EN
    logic [LANE_W-1:0] chk_q, chk_d;
    logic              chk_pend_q, chk_pend_d;

    always_comb begin
        chk_d      = chk_q;
        chk_pend_d = chk_pend_q;
        chk_push   = 1'b0;
        if (accept) begin
            chk_d      = '0;
            chk_pend_d = 1'b1;
        end else begin
            if (arrive) chk_d = chk_q ^ lane_data;
            if (state_q == ST_DRAIN && chk_pend_q && vld_pipe_q == '0 && credit_q < CRD_MAX) begin
                chk_push   = 1'b1;
                chk_pend_d = 1'b0;
            end
        end
        chk_busy  = chk_pend_q;
        chk_value = chk_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q      <= '0;
            chk_pend_q <= 1'b0;
        end else begin
            chk_q      <= chk_d;
            chk_pend_q <= chk_pend_d;
        end
    end
`else
    always_comb begin
        chk_push  = 1'b0;
        chk_busy  = 1'b0;
        chk_value = '0;
    end
`endif

    always_comb begin
        conf_ready   = (state_q == ST_IDLE);
        pbuf_rd_en   = issue ? cur_bit : '0;
        pbuf_rd_addr = addr_q;
        ddr_valid    = (fcnt_q != '0);
        ddr_data     = '0;
        if (ddr_valid) ddr_data[LANE_W-1:0] = fifo_mem_q[rd_ptr_q];
        ddr_last     = ddr_valid && (word_cnt_q == last_idx_q);
    end

    always_comb begin
        pop       = ddr_valid && ddr_ready;
        push      = arrive || chk_push;
        push_data = chk_push ? chk_value : lane_data;
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + CRD_W'(1);
            2'b01:   fcnt_d = fcnt_q - CRD_W'(1);
            default: fcnt_d = fcnt_q;
        endcase
        credit_d   = credit_q + CRD_W'(issue) + CRD_W'(chk_push) - CRD_W'(pop);
        wr_ptr_d   = push ? wr_ptr_q + FP_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + FP_W'(1) : rd_ptr_q;
        word_cnt_d = accept ? '0 : (pop ? word_cnt_q + CNT_W'(1) : word_cnt_q);
        vld_pipe_d    = '0;
        pe_pipe_d     = '0;
        vld_pipe_d[0] = issue;
        pe_pipe_d[0]  = cur_pe;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            pe_pipe_d[i]  = pe_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            depth_q    <= '0;
            addr_q     <= '0;
            last_idx_q <= '0;
            word_cnt_q <= '0;
            credit_q   <= '0;
            fcnt_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            vld_pipe_q <= '0;
            pe_pipe_q  <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            depth_q    <= depth_d;
            addr_q     <= addr_d;
            last_idx_q <= last_idx_d;
            word_cnt_q <= word_cnt_d;
            credit_q   <= credit_d;
            fcnt_q     <= fcnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            vld_pipe_q <= vld_pipe_d;
            pe_pipe_q  <= pe_pipe_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: tb/tb_pbuf2ddr.sv
// Directed self-checking bench for pbuf2ddr; honours PBUF2DDR_CHKSUM_EN when defined.
module tb_pbuf2ddr;
    timeunit 1ns;
    timeprecision 1ns;

    localparam int unsigned BUF_DEPTH  = 256;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned PE_NUM     = 32;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned BATCH      = 2;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned DDR_W      = 64;
    localparam int unsigned LANE_W     = BATCH * DATA_W;
`ifdef PBUF2DDR_CHKSUM_EN
    localparam int unsigned CHK = 1;
`else
    localparam int unsigned CHK = 0;
`endif

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        conf_valid;
    logic                        conf_ready;
    logic [PE_NUM-1:0]           conf_mask;
    logic [ADDR_W-1:0]           conf_depth;
    logic [PE_NUM-1:0]           pbuf_rd_en;
    logic [ADDR_W-1:0]           pbuf_rd_addr;
    logic [PE_NUM*LANE_W-1:0]    pbuf_rd_data;
    logic [DDR_W-1:0]            ddr_data;
    logic                        ddr_valid;
    logic                        ddr_ready;
    logic                        ddr_last;

    always #5 clk = ~clk;

    pbuf2ddr #(
        .BUF_DEPTH (BUF_DEPTH),
        .ADDR_W    (ADDR_W),
        .PE_NUM    (PE_NUM),
        .RD_LAT    (RD_LAT),
        .FIFO_DEPTH(FIFO_DEPTH),
        .BATCH     (BATCH),
        .DATA_W    (DATA_W),
        .DDR_W     (DDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .conf_valid  (conf_valid),
        .conf_ready  (conf_ready),
        .conf_mask   (conf_mask),
        .conf_depth  (conf_depth),
        .pbuf_rd_en  (pbuf_rd_en),
        .pbuf_rd_addr(pbuf_rd_addr),
        .pbuf_rd_data(pbuf_rd_data),
        .ddr_data    (ddr_data),
        .ddr_valid   (ddr_valid),
        .ddr_ready   (ddr_ready),
        .ddr_last    (ddr_last)
    );

    // pbuf model: two-cycle read latency; a lane not strobed returns a poison pattern.
    logic [LANE_W-1:0] pmem [PE_NUM][BUF_DEPTH];
    logic [PE_NUM-1:0] en_d1, en_d2;
    logic [ADDR_W-1:0] a_d1, a_d2;

    always @(posedge clk) begin
        en_d1 <= pbuf_rd_en;
        a_d1  <= pbuf_rd_addr;
        en_d2 <= en_d1;
        a_d2  <= a_d1;
    end

    always_comb begin
        pbuf_rd_data = '0;
        for (int p = 0; p < PE_NUM; p++) begin
            pbuf_rd_data[p*LANE_W +: LANE_W] = en_d2[p] ? pmem[p][a_d2] : (32'hBAD0_0000 | 32'(p));
        end
    end

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned rd_total = 0;
    logic [63:0] got_d[$];
    logic        got_l[$];
    time         got_t[$];
    logic [63:0] exp_q[$];
    time         t0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: records handshakes, checks stall stability and one-hot read strobes.
    initial begin
        logic        hold;
        logic [63:0] hold_d;
        logic        hold_l;
        hold = 1'b0;
        hold_d = '0;
        hold_l = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("stall_valid", {63'd0, ddr_valid}, 64'd1);
                    chk("stall_data", ddr_data, hold_d);
                    chk("stall_last", {63'd0, ddr_last}, {63'd0, hold_l});
                end
                total++;
                assert ($onehot0(pbuf_rd_en)) else begin
                    bad++;
                    $error("FAIL rd_en_onehot observed=%0h expected=onehot0", pbuf_rd_en);
                end
                if (pbuf_rd_en != '0) rd_total++;
                if (ddr_valid && ddr_ready) begin
                    got_d.push_back(ddr_data);
                    got_l.push_back(ddr_last);
                    got_t.push_back($time);
                end
                hold   = ddr_valid && !ddr_ready;
                hold_d = ddr_data;
                hold_l = ddr_last;
            end
        end
    end

    task automatic start(input logic [PE_NUM-1:0] m, input logic [ADDR_W-1:0] d, input string tag);
        conf_valid = 1'b1;
        conf_mask  = m;
        conf_depth = d;
        @(posedge clk);
        t0 = $time;
        #1;
        conf_valid = 1'b0;
        chk({tag, "_ready_drop"}, {63'd0, conf_ready}, 64'd0);
    endtask

    task automatic wait_words(input string tag, input int unsigned n, input int unsigned budget);
        int unsigned k = 0;
        while (got_d.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        total++;
        assert (got_d.size() >= n) else begin
            bad++;
            $error("FAIL %s_timeout observed=%0d expected=%0d", tag, got_d.size(), n);
        end
    endtask

    task automatic wait_idle(input string tag);
        int unsigned k = 0;
        while (!conf_ready && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_idle"}, {63'd0, conf_ready}, 64'd1);
    endtask

    // Compares captured words against exp_q (plus the XOR word when the checksum is built).
    task automatic check_words(input string tag);
        logic [63:0] x = '0;
        int unsigned n;
        repeat (4) @(posedge clk);
        #1;
        foreach (exp_q[i]) x = x ^ exp_q[i];
        if (CHK != 0) exp_q.push_back(x);
        n = exp_q.size();
        chk({tag, "_count"}, 64'(got_d.size()), 64'(n));
        for (int unsigned i = 0; i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i), (i < got_d.size()) ? got_d[i] : 64'hDEAD, exp_q[i]);
            chk($sformatf("%s_last%0d", tag, i), (i < got_l.size()) ? {63'd0, got_l[i]} : 64'hDEAD,
                {63'd0, (i == n - 1)});
        end
        got_d.delete();
        got_l.delete();
        got_t.delete();
        exp_q.delete();
    endtask

    initial begin
        int unsigned rd_base;
        int unsigned k;
        rst        = 1'b1;
        conf_valid = 1'b0;
        conf_mask  = '0;
        conf_depth = '0;
        ddr_ready  = 1'b1;
        for (int p = 0; p < PE_NUM; p++) begin
            for (int a = 0; a < BUF_DEPTH; a++) pmem[p][a] = 32'((p << 16) | (a + 1));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_conf_ready", {63'd0, conf_ready}, 64'd1);
        chk("rst_rd_en", 64'(pbuf_rd_en), 64'd0);
        chk("rst_rd_addr", 64'(pbuf_rd_addr), 64'd0);
        chk("rst_valid", {63'd0, ddr_valid}, 64'd0);
        chk("rst_last", {63'd0, ddr_last}, 64'd0);
        chk("rst_data", ddr_data, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: single PE, depth 3, latency and back-to-back output
        start(32'h1, 8'd3, "t1");
        chk("t1_rd_en", 64'(pbuf_rd_en), 64'd1);
        chk("t1_rd_addr", 64'(pbuf_rd_addr), 64'd0);
        wait_words("t1", 4 + CHK, 60);
        chk("t1_first_valid_time", 64'(got_t[0]), 64'(t0 + 10 * (RD_LAT + 1) + 5));
        chk("t1_back_to_back", 64'(got_t[3] - got_t[0]), 64'd30);
        exp_q = '{64'd1, 64'd2, 64'd3, 64'd4};
        check_words("t1");
        wait_idle("t1");

        // 2: sparse mask, PE0 then PE2 then PE31, no bubble between PEs
        start(32'h8000_0005, 8'd1, "t2");
        wait_words("t2", 6 + CHK, 60);
        chk("t2_no_bubble", 64'(got_t[5] - got_t[0]), 64'd50);
        exp_q = '{64'h1, 64'h2, 64'h2_0001, 64'h2_0002, 64'h1F_0001, 64'h1F_0002};
        check_words("t2");
        wait_idle("t2");

        // 3: backpressure; credits cap outstanding reads at FIFO_DEPTH
        ddr_ready = 1'b0;
        rd_base   = rd_total;
        start(32'h1, 8'd15, "t3");
        repeat (20) @(posedge clk);
        #1;
        chk("t3_credit_stop", 64'(rd_total - rd_base), 64'(FIFO_DEPTH));
        chk("t3_no_words_yet", 64'(got_d.size()), 64'd0);
        chk("t3_valid_held", {63'd0, ddr_valid}, 64'd1);
        k = 0;
        while (got_d.size() < 16 + CHK && k < 300) begin
            ddr_ready = (k % 3 == 0);
            @(posedge clk);
            #1;
            k++;
        end
        ddr_ready = 1'b1;
        wait_words("t3", 16 + CHK, 10);
        for (int i = 1; i <= 16; i++) exp_q.push_back(64'(i));
        check_words("t3");
        wait_idle("t3");

        // 4: empty mask
        start(32'h0, 8'd7, "t4");
        @(posedge clk);
        #1;
        if (CHK == 0) chk("t4_ready_2cyc", {63'd0, conf_ready}, 64'd1);
        wait_words("t4", CHK, 20);
        check_words("t4");
        wait_idle("t4");

        // 5: reset mid-transfer, then a clean rerun
        start(32'h1, 8'd15, "t5");
        k = 0;
        while (got_d.size() < 5 && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("t5_reached_word5", 64'(got_d.size()), 64'd5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_abort_valid", {63'd0, ddr_valid}, 64'd0);
        chk("t5_abort_rd_en", 64'(pbuf_rd_en), 64'd0);
        chk("t5_abort_ready", {63'd0, conf_ready}, 64'd1);
        chk("t5_abort_last", {63'd0, ddr_last}, 64'd0);
        rst = 1'b0;
        got_d.delete();
        got_l.delete();
        got_t.delete();
        start(32'h1, 8'd3, "t5b");
        wait_words("t5b", 4 + CHK, 60);
        exp_q = '{64'd1, 64'd2, 64'd3, 64'd4};
        check_words("t5b");
        wait_idle("t5b");

`ifdef PBUF2DDR_CHKSUM_EN
        // 6: checksum word
        pmem[0][0] = 32'hA5;
        pmem[1][0] = 32'h0F;
        start(32'h3, 8'd0, "t6");
        wait_words("t6", 3, 40);
        chk("t6_chk_word", got_d[2], 64'hAA);
        exp_q = '{64'hA5, 64'h0F};
        check_words("t6");
        wait_idle("t6");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
